// File: rtl/fetchq_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Each entry holds the fetched instruction and its fetch address + 4.
package fetchq_pkg;

  localparam int          FETCHQ_DEPTH     = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetchq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory, IF/ID and redirect signals around the fetch queue.
// The queue connects through the master modport; its environment uses the slave modport.
interface fetch_queue_if
  import fetchq_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
);

  logic [31:0]                  imem_addr;
  logic [31:0]                  imem_instr;
  logic                         out_valid;
  logic [31:0]                  out_instr;
  logic [31:0]                  out_pc4;
  logic                         out_ready;
  logic                         redirect_valid;
  logic [31:0]                  redirect_pc;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    output out_instr,
    output out_pc4,
    input  out_ready,
    input  redirect_valid,
    input  redirect_pc,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    input  out_instr,
    input  out_pc4,
    output out_ready,
    output redirect_valid,
    output redirect_pc,
    input  count
  );

endinterface

// File: rtl/fetchq_store.sv
// Entry storage for the fetch queue: DEPTH x 64-bit registers,
// one synchronous write port and one asynchronous read port.
module fetchq_store
  import fetchq_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                     Clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  fetchq_entry_t            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output fetchq_entry_t            rd_data
);

  fetchq_entry_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and IF/ID; owns the fetch PC.
// Optional zero-latency path from memory to the head when empty: define FETCHQ_BYPASS_EN.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int          DEPTH    = FETCHQ_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          Clk,
  input  logic          Rst,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic          not_empty;
  logic          not_full;
  logic          out_valid_c;
  logic          pop;
  logic          push;
  logic          store_wr;
  logic          store_rd;
  logic [31:0]   fetch_pc4;
  logic [31:0]   out_instr_c;
  logic [31:0]   out_pc4_c;
  fetchq_entry_t head;
  fetchq_entry_t wr_entry;

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != CW'(DEPTH));
  assign fetch_pc4 = fetch_pc + 32'd4;
  assign wr_entry  = '{instr: bus.imem_instr, pc4: fetch_pc4};

  // A redirect blocks the push; a full queue can still push when the head leaves.
  always_comb begin
    out_valid_c = not_empty;
    out_instr_c = not_empty ? head.instr : NOP;
    out_pc4_c   = not_empty ? head.pc4   : 32'h0;
`ifdef FETCHQ_BYPASS_EN
    if (!not_empty && !bus.redirect_valid) begin
      out_valid_c = 1'b1;
      out_instr_c = bus.imem_instr;
      out_pc4_c   = fetch_pc4;
    end
    pop      = out_valid_c & bus.out_ready;
    push     = (not_full | pop) & ~bus.redirect_valid;
    store_wr = push & ~(~not_empty & bus.out_ready);
    store_rd = pop & not_empty;
`else
    pop      = out_valid_c & bus.out_ready;
    push     = (not_full | pop) & ~bus.redirect_valid;
    store_wr = push;
    store_rd = pop;
`endif
  end

  // Reset outranks redirect, which in turn flushes everything including a coincident pop.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc4;
      end
      if (store_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (store_rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({store_wr, store_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fetchq_store #(
    .DEPTH(DEPTH)
  ) u_store (
    .Clk     (Clk),
    .wr_en   (store_wr & Rst),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = out_instr_c;
  assign bus.out_pc4   = out_pc4_c;
  assign bus.count     = count_q;

endmodule
